// File: rtl/adas_pkg.sv
// Shared constants for the longitudinal speed controller: FSM state encodings
// and the default set-speed / following-distance / actuation tuning values.
package adas_pkg;

    localparam logic [2:0] ST_ASSIST = 3'd0;
    localparam logic [2:0] ST_CRUISE = 3'd1;
    localparam logic [2:0] ST_FOLLOW = 3'd2;
    localparam logic [2:0] ST_XWALK  = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_HOLD   = 3'd5;

    localparam int DEF_W           = 8;
    localparam int DEF_N_SENS      = 2;
    localparam int DEF_VOTE        = 2;
    localparam int DEF_SPEED_VAL   = 100;
    localparam int DEF_FOLLOW_VAL  = 50;
    localparam int DEF_XWALK_SPEED = 20;
    localparam int DEF_HYST        = 2;
    localparam int DEF_HOLD_TICKS  = 4;

endpackage

// File: rtl/adas_sensor_fuse.sv
// Combinational fusion of N redundant sensor channels: majority-style votes for
// redlight/crosswalk and the nearest distance among channels flagged valid.
module adas_sensor_fuse #(
    parameter int W      = 8,
    parameter int N_SENS = 2,
    parameter int VOTE   = 2
) (
    input  logic [N_SENS-1:0]   redlight_i,
    input  logic [N_SENS-1:0]   crosswalk_i,
    input  logic [N_SENS*W-1:0] distance_i,
    input  logic [N_SENS-1:0]   dist_valid_i,
    output logic                red_vote_o,
    output logic                xwalk_vote_o,
    output logic [W-1:0]        dist_min_o
);

    localparam int CW = $clog2(N_SENS + 1);

    // Invalid channels read as all-ones so they never win the minimum and the
    // result is all-ones when no channel is valid.
    logic [W-1:0] w_dist_masked [N_SENS];

    genvar gi;
    generate
        for (gi = 0; gi < N_SENS; gi++) begin : g_ch
            assign w_dist_masked[gi] = dist_valid_i[gi] ? distance_i[gi*W +: W] : '1;
        end
    endgenerate

    logic [CW-1:0] w_red_cnt;
    logic [CW-1:0] w_xw_cnt;
    logic [W-1:0]  w_min;

    always_comb begin
        w_red_cnt = '0;
        w_xw_cnt  = '0;
        w_min     = '1;
        for (int k = 0; k < N_SENS; k++) begin
            w_red_cnt = w_red_cnt + CW'(redlight_i[k]);
            w_xw_cnt  = w_xw_cnt + CW'(crosswalk_i[k]);
            if (w_dist_masked[k] < w_min) begin
                w_min = w_dist_masked[k];
            end
        end
    end

    assign red_vote_o   = (w_red_cnt >= CW'(VOTE));
    assign xwalk_vote_o = (w_xw_cnt >= CW'(VOTE));
    assign dist_min_o   = w_min;

endmodule

// File: rtl/adas_speed_ctrl.sv
// Tick-gated longitudinal controller: picks a target speed from fused sensor
// votes and following distance, then drives gas/brake with a hysteresis band.
module adas_speed_ctrl
    import adas_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int N_SENS      = DEF_N_SENS,
    parameter int VOTE        = DEF_VOTE,
    parameter int DEF_SPEED   = DEF_SPEED_VAL,
    parameter int DEF_FOLLOW  = DEF_FOLLOW_VAL,
    parameter int XWALK_SPEED = DEF_XWALK_SPEED,
    parameter int HYST        = DEF_HYST,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_i,
    input  logic                mode_i,
    input  logic [N_SENS-1:0]   redlight_i,
    input  logic [N_SENS-1:0]   crosswalk_i,
    input  logic [N_SENS*W-1:0] distance_i,
    input  logic [N_SENS-1:0]   dist_valid_i,
    input  logic [W-1:0]        speed_measured_i,
    input  logic [W-1:0]        speed_set_i,
    input  logic [W-1:0]        follow_dist_i,
    output logic                gas_o,
    output logic                brake_o,
    output logic [W-1:0]        target_speed_o,
    output logic [2:0]          state_o,
    output logic                redlight_o,
    output logic                crosswalk_o,
    output logic                follow_warn_o
);

    localparam int HCW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic         w_red_v;
    logic         w_xw_v;
    logic [W-1:0] w_dist_f;

    adas_sensor_fuse #(
        .W      (W),
        .N_SENS (N_SENS),
        .VOTE   (VOTE)
    ) u_fuse (
        .redlight_i   (redlight_i),
        .crosswalk_i  (crosswalk_i),
        .distance_i   (distance_i),
        .dist_valid_i (dist_valid_i),
        .red_vote_o   (w_red_v),
        .xwalk_vote_o (w_xw_v),
        .dist_min_o   (w_dist_f)
    );

    logic [2:0]     r_state;
    logic [HCW-1:0] r_hold_cnt;
    logic           r_gas;
    logic           r_brake;
    logic [W-1:0]   r_target;
    logic           r_red_warn;
    logic           r_xw_warn;
    logic           r_fol_warn;

    logic [W-1:0]   w_set;
    logic [W-1:0]   w_fol;
    logic           w_too_close;

    assign w_set       = (speed_set_i == '0) ? W'(DEF_SPEED) : speed_set_i;
    assign w_fol       = (follow_dist_i == '0) ? W'(DEF_FOLLOW) : follow_dist_i;
    assign w_too_close = (w_dist_f < w_fol);

    logic [2:0]     w_state_next;
    logic [HCW-1:0] w_hold_next;

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = '0;
        if (!mode_i) begin
            w_state_next = ST_ASSIST;
        end else if (w_red_v) begin
            w_state_next = ST_STOP;
        end else if (r_state == ST_STOP && speed_measured_i == '0) begin
            w_state_next = ST_HOLD;
            w_hold_next  = HCW'(HOLD_TICKS - 1);
        end else if (r_state == ST_STOP) begin
            w_state_next = ST_STOP;
        end else if (r_state == ST_HOLD && r_hold_cnt != '0) begin
            w_state_next = ST_HOLD;
            w_hold_next  = r_hold_cnt - HCW'(1);
        end else if (w_xw_v) begin
            w_state_next = ST_XWALK;
        end else if (w_too_close) begin
            w_state_next = ST_FOLLOW;
        end else begin
            w_state_next = ST_CRUISE;
        end
    end

    logic [W-1:0] w_target_next;

    always_comb begin
        w_target_next = '0;
        case (w_state_next)
            ST_CRUISE: w_target_next = w_set;
            ST_XWALK:  w_target_next = (w_set < W'(XWALK_SPEED)) ? w_set : W'(XWALK_SPEED);
            ST_FOLLOW: w_target_next = (w_dist_f < (w_fol >> 1)) ? '0 : (w_set >> 1);
            default:   w_target_next = '0;
        endcase
    end

    // One extra bit keeps tgt+HYST and meas+HYST from wrapping near full scale.
    logic [W:0] w_meas_x;
    logic [W:0] w_tgt_x;
    logic [W:0] w_hyst_x;
    logic       w_gas_next;
    logic       w_brake_next;

    assign w_meas_x = {1'b0, speed_measured_i};
    assign w_tgt_x  = {1'b0, w_target_next};
    assign w_hyst_x = (W + 1)'(HYST);

    always_comb begin
        w_gas_next   = 1'b0;
        w_brake_next = 1'b0;
        if (w_state_next == ST_ASSIST) begin
            w_gas_next   = 1'b0;
            w_brake_next = 1'b0;
        end else if (w_state_next == ST_STOP || w_state_next == ST_HOLD) begin
            w_brake_next = 1'b1;
        end else if (w_meas_x > w_tgt_x + w_hyst_x) begin
            w_brake_next = 1'b1;
        end else if (w_meas_x + w_hyst_x < w_tgt_x) begin
            w_gas_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ASSIST;
            r_hold_cnt <= '0;
            r_gas      <= 1'b0;
            r_brake    <= 1'b0;
            r_target   <= '0;
            r_red_warn <= 1'b0;
            r_xw_warn  <= 1'b0;
            r_fol_warn <= 1'b0;
        end else if (tick_i) begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_gas      <= w_gas_next;
            r_brake    <= w_brake_next;
            r_target   <= w_target_next;
            r_red_warn <= w_red_v;
            r_xw_warn  <= w_xw_v;
            r_fol_warn <= w_too_close;
        end
    end

    assign gas_o          = r_gas;
    assign brake_o        = r_brake;
    assign target_speed_o = r_target;
    assign state_o        = r_state;
    assign redlight_o     = r_red_warn;
    assign crosswalk_o    = r_xw_warn;
    assign follow_warn_o  = r_fol_warn;

endmodule

// File: tb/tb_adas_speed_ctrl.sv
// Scoreboard bench for adas_speed_ctrl: hand-derived expectations are queued as
// each tick is driven and compared once the registered outputs settle.
module tb_adas_speed_ctrl;

    localparam int W = 8;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           tick_i;
    logic           mode_i;
    logic [N-1:0]   redlight_i;
    logic [N-1:0]   crosswalk_i;
    logic [N*W-1:0] distance_i;
    logic [N-1:0]   dist_valid_i;
    logic [W-1:0]   speed_measured_i;
    logic [W-1:0]   speed_set_i;
    logic [W-1:0]   follow_dist_i;
    logic           gas_o;
    logic           brake_o;
    logic [W-1:0]   target_speed_o;
    logic [2:0]     state_o;
    logic           redlight_o;
    logic           crosswalk_o;
    logic           follow_warn_o;

    always #5 clk = ~clk;

    adas_speed_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tick_i           (tick_i),
        .mode_i           (mode_i),
        .redlight_i       (redlight_i),
        .crosswalk_i      (crosswalk_i),
        .distance_i       (distance_i),
        .dist_valid_i     (dist_valid_i),
        .speed_measured_i (speed_measured_i),
        .speed_set_i      (speed_set_i),
        .follow_dist_i    (follow_dist_i),
        .gas_o            (gas_o),
        .brake_o          (brake_o),
        .target_speed_o   (target_speed_o),
        .state_o          (state_o),
        .redlight_o       (redlight_o),
        .crosswalk_o      (crosswalk_o),
        .follow_warn_o    (follow_warn_o)
    );

    typedef struct {
        string tag;
        int    st;
        int    tgt;
        int    gas;
        int    brk;
        int    rw;
        int    xw;
        int    fw;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_checks++;
        if (obs !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic push_exp(input string tag, input int st, input int tgt, input int gas,
                            input int brk, input int rw, input int xw, input int fw);
        exp_t e;
        e.tag = tag; e.st = st; e.tgt = tgt; e.gas = gas; e.brk = brk;
        e.rw = rw; e.xw = xw; e.fw = fw;
        sb_q.push_back(e);
        last_e = e;
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            $display("txn %-12s state=%0d tgt=%0d gas=%0b brake=%0b red=%0b xw=%0b fol=%0b",
                     e.tag, state_o, target_speed_o, gas_o, brake_o,
                     redlight_o, crosswalk_o, follow_warn_o);
            check_val({e.tag, ".state"}, 32'(state_o), 32'(e.st));
            check_val({e.tag, ".tgt"},   32'(target_speed_o), 32'(e.tgt));
            check_val({e.tag, ".gas"},   32'(gas_o), 32'(e.gas));
            check_val({e.tag, ".brake"}, 32'(brake_o), 32'(e.brk));
            check_val({e.tag, ".redw"},  32'(redlight_o), 32'(e.rw));
            check_val({e.tag, ".xww"},   32'(crosswalk_o), 32'(e.xw));
            check_val({e.tag, ".folw"},  32'(follow_warn_o), 32'(e.fw));
        end
    endtask

    task automatic do_tick(input string tag, input int st, input int tgt, input int gas,
                           input int brk, input int rw, input int xw, input int fw);
        push_exp(tag, st, tgt, gas, brk, rw, xw, fw);
        tick_i = 1'b1;
        @(posedge clk);
        #1;
        tick_i = 1'b0;
        compare_pop();
    endtask

    // Clock edge without a tick: outputs must repeat the previous expectation.
    task automatic idle_clk(input string tag);
        push_exp(tag, last_e.st, last_e.tgt, last_e.gas, last_e.brk, last_e.rw, last_e.xw, last_e.fw);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tick_i = 1'b0; mode_i = 1'b1;
        redlight_i = '0; crosswalk_i = '0; distance_i = '0; dist_valid_i = '0;
        speed_measured_i = 8'd50; speed_set_i = 8'd0; follow_dist_i = 8'd0;

        push_exp("reset", 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        compare_pop();
        rst = 1'b0;

        // Default set speed, far below target -> accelerate
        do_tick("cruise", 1, 100, 1, 0, 0, 0, 0);

        // One of two channels is not a vote
        redlight_i = 2'b01; speed_measured_i = 8'd60;
        do_tick("red_1of2", 1, 100, 1, 0, 0, 0, 0);
        redlight_i = 2'b11;
        do_tick("red_2of2", 4, 0, 0, 1, 1, 0, 0);

        // Standstill hold: 4 ticks in HOLD then back to cruise
        redlight_i = 2'b00; speed_measured_i = 8'd0;
        do_tick("hold1", 5, 0, 0, 1, 0, 0, 0);
        do_tick("hold2", 5, 0, 0, 1, 0, 0, 0);
        do_tick("hold3", 5, 0, 0, 1, 0, 0, 0);
        do_tick("hold4", 5, 0, 0, 1, 0, 0, 0);
        do_tick("hold_exit", 1, 100, 1, 0, 0, 0, 0);

        // Following: only ch1 valid, ch0 holds a nearer but invalid reading
        dist_valid_i = 2'b10; distance_i = {8'd20, 8'd5};
        speed_set_i = 8'd80; speed_measured_i = 8'd40;
        do_tick("follow_near", 2, 0, 0, 1, 0, 0, 1);
        distance_i = {8'd30, 8'd5};
        do_tick("follow_far", 2, 40, 0, 0, 0, 0, 1);
        follow_dist_i = 8'd25;
        do_tick("follow_clear", 1, 80, 1, 0, 0, 0, 0);

        // Crosswalk cap with hysteresis boundaries
        dist_valid_i = 2'b00; follow_dist_i = 8'd0;
        crosswalk_i = 2'b11; speed_measured_i = 8'd21;
        do_tick("xw_coast21", 3, 20, 0, 0, 0, 1, 0);
        speed_measured_i = 8'd22;
        do_tick("xw_coast22", 3, 20, 0, 0, 0, 1, 0);
        speed_measured_i = 8'd23;
        do_tick("xw_brake23", 3, 20, 0, 1, 0, 1, 0);
        speed_measured_i = 8'd17;
        do_tick("xw_gas17", 3, 20, 1, 0, 0, 1, 0);

        // Red and crosswalk together: STOP wins
        redlight_i = 2'b11; speed_measured_i = 8'd30;
        do_tick("red_and_xw", 4, 0, 0, 1, 1, 1, 0);

        // Drop to assist mid-stop: actuators released, warnings keep tracking
        mode_i = 1'b0;
        do_tick("assist_stop", 0, 0, 0, 0, 1, 1, 0);
        redlight_i = 2'b00;
        do_tick("assist_trk", 0, 0, 0, 0, 0, 1, 0);

        // No tick: inputs change but outputs hold
        crosswalk_i = 2'b00; mode_i = 1'b1;
        idle_clk("idle1");
        redlight_i = 2'b11; speed_measured_i = 8'd99;
        idle_clk("idle2");
        speed_set_i = 8'd0; dist_valid_i = 2'b11; distance_i = {8'd1, 8'd1};
        idle_clk("idle3");

        // Back to cruise, then reset without a tick
        redlight_i = 2'b00; dist_valid_i = 2'b00; speed_measured_i = 8'd50;
        do_tick("cruise2", 1, 100, 1, 0, 0, 0, 0);
        rst = 1'b1;
        push_exp("mid_reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        compare_pop();
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
